// File: rtl/neural_soc_to_sw_result_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ hardware results into one 32-bit
// software PIO word, holding each result until software toggles its ack bit.
module neural_soc_to_sw_result_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      sw_ack_tgl,
  output logic [31:0]               sw_word,
  output logic                      busy
);

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_t;

  state_t              state;
  logic                ack_meta;
  logic                ack_s;
  logic                ack_seen;
  logic                ack_evt;
  logic [2:0]          last;
  logic                valid_q;
  logic [2:0]          src_q;
  logic                spur_q;
  logic [2:0]          seq_q;
  logic [DATA_W-1:0]   data_q;

  logic [NUM_REQ-1:0]  grant;
  logic [2:0]          gnt_idx;
  logic [DATA_W-1:0]   gnt_data;
  logic                found;
  logic                take;

  assign ack_evt = (ack_s != ack_seen);

  // Two-pass priority search: indices above the last grant first, then wrap.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant    = '0;
    gnt_idx  = last;
    gnt_data = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i > int'(last))) begin
        grant[i] = 1'b1;
        gnt_idx  = 3'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i <= int'(last))) begin
        grant[i] = 1'b1;
        gnt_idx  = 3'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Reset also masks the combinational grant so producers never see ready
  // while the block is held in reset.
  assign req_ready = (state == IDLE && reset_n) ? grant : '0;
  assign take      = (state == IDLE) && found;

  assign sw_word = {valid_q, src_q, spur_q, seq_q, 24'(data_q)};
  assign busy    = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
      ack_seen <= 1'b0;
      last     <= 3'(NUM_REQ - 1);
      valid_q  <= 1'b0;
      src_q    <= '0;
      spur_q   <= 1'b0;
      seq_q    <= '0;
      data_q   <= '0;
    end else begin
      ack_meta <= sw_ack_tgl;
      ack_s    <= ack_meta;
      ack_seen <= ack_s;
      case (state)
        IDLE: begin
          if (ack_evt) spur_q <= 1'b1;
          if (take) begin
            data_q  <= gnt_data;
            src_q   <= gnt_idx;
            valid_q <= 1'b1;
            seq_q   <= seq_q + 3'd1;
            last    <= gnt_idx;
            state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_evt) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
